inst_queue: RTL and testbench

- Decoupling instruction queue between the IF stage and the ID stage.
- Accepts fetch packets (fs_to_ds_bus) whenever it has room, so an ID stall does not stall the icache handshake.
- Presents packets in order to decode.
- On any pipeline flush, including a BTB mispredict redirect from ID, all buffered packets are discarded.

---
 rtl/inst_queue_pkg.sv | 21 ++
 rtl/iq_ram.sv | 37 +++
 rtl/inst_queue.sv | 74 +++++++
 tb/tb_inst_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: fetch packet width,
// field offsets inside fs_to_ds_bus, and default queue geometry.
package inst_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 109;
    localparam int IQ_DEPTH        = 4;
    localparam int IQ_PTR_W        = 2;

    // Packet layout, LSB first: pc, inst, excp_num, excp, icache_miss,
    // btb_en, btb_taken, btb_index, btb_ret_pc.
    localparam int PC_LSB          = 0;
    localparam int INST_LSB        = 32;
    localparam int EXCP_NUM_LSB    = 64;
    localparam int EXCP_BIT        = 68;
    localparam int ICACHE_MISS_BIT = 69;
    localparam int BTB_EN_BIT      = 70;
    localparam int BTB_TAKEN_BIT   = 71;
    localparam int BTB_INDEX_LSB   = 72;
    localparam int BTB_RET_PC_LSB  = 77;

endpackage

// File: rtl/iq_ram.sv
// DEPTH x W register array for the instruction queue: one synchronous write
// port, one combinational read port, whole array cleared on reset.
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = IQ_PTR_W,
    parameter int W     = FS_TO_DS_BUS_WD
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Entry storage: cleared asynchronously, written on push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head read is combinational so decode sees the packet in the cycle after it was written.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/inst_queue.sv
// Decoupling instruction queue between IF and ID. IF pushes whenever there
// is room, ID pops the head in order, and any flush discards all entries.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PTR_W  = IQ_PTR_W,
    parameter int BUS_WD = FS_TO_DS_BUS_WD
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fs_to_ds_valid,
    input  logic [BUS_WD-1:0] fs_to_ds_bus,
    output logic              iq_allowin,
    output logic              iq_to_ds_valid,
    output logic [BUS_WD-1:0] iq_to_ds_bus,
    input  logic              ds_allowin,
    input  logic              flush,
    output logic [PTR_W:0]    iq_count,
    output logic              iq_empty,
    output logic              iq_full
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           push;
    logic           pop;

    // Occupancy, handshake and push/pop qualification.
    always_comb begin
        iq_count       = wr_ptr - rd_ptr;
        iq_empty       = (wr_ptr == rd_ptr);
        iq_full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        // Ready deliberately ignores ds_allowin: no combinational path from ID to icache.
        iq_allowin     = !iq_full;
        iq_to_ds_valid = !iq_empty && !flush;
        push           = fs_to_ds_valid && iq_allowin && !flush;
        pop            = iq_to_ds_valid && ds_allowin && !flush;
    end

    // Pointer update; a flush snaps the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W),
        .W     (BUS_WD)
    ) u_iq_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (push),
        .waddr  (wr_ptr[PTR_W-1:0]),
        .wdata  (fs_to_ds_bus),
        .raddr  (rd_ptr[PTR_W-1:0]),
        .rdata  (iq_to_ds_bus)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/stall, full with concurrent pop,
// streaming across pointer wrap, flush, exception payload and async reset.
module tb_inst_queue;

    localparam int BUS_WD = 109;
    localparam int PTR_W  = 2;

    logic              clk;
    logic              resetn;
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              iq_allowin;
    logic              iq_to_ds_valid;
    logic [BUS_WD-1:0] iq_to_ds_bus;
    logic              ds_allowin;
    logic              flush;
    logic [PTR_W:0]    iq_count;
    logic              iq_empty;
    logic              iq_full;

    int n_vec;
    int n_bad;

    inst_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .iq_allowin     (iq_allowin),
        .iq_to_ds_valid (iq_to_ds_valid),
        .iq_to_ds_bus   (iq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .flush          (flush),
        .iq_count       (iq_count),
        .iq_empty       (iq_empty),
        .iq_full        (iq_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a packet whose every field is derived from pc, so the whole bus is checked.
    function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic excp,
                                             input logic [3:0] num);
        return {pc + 32'h100, pc[6:2], pc[2], pc[3], 1'b0, excp, num, ~pc, pc};
    endfunction

    function automatic logic [BUS_WD-1:0] pk(input int i);
        return mk(32'h1c000000 + 32'(4 * i), 1'b0, 4'h0);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic vld);
        check_eq({tag, " count"}, 128'(iq_count), 128'(cnt));
        check_eq({tag, " valid"}, 128'(iq_to_ds_valid), 128'(vld));
        check_eq({tag, " empty"}, 128'(iq_empty), 128'(cnt == 0));
        check_eq({tag, " full"}, 128'(iq_full), 128'(cnt == 4));
        check_eq({tag, " allowin"}, 128'(iq_allowin), 128'(cnt != 4));
    endtask

    initial begin
        logic [BUS_WD-1:0] xp;
        n_vec = 0;
        n_bad = 0;

        // Reset held with IF presenting a packet.
        resetn         = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = pk(0);
        ds_allowin     = 1'b0;
        flush          = 1'b0;
        #8;
        check_state("reset", 0, 1'b0);
        check_eq("reset bus", 128'(iq_to_ds_bus), 128'(0));
        #4;
        resetn = 1'b1;
        #1;
        check_state("post-release no bypass", 0, 1'b0);

        // Fill with ID stalled.
        tick();
        check_state("fill1", 1, 1'b1);
        check_eq("fill1 pc", 128'(iq_to_ds_bus[31:0]), 128'(32'h1c000000));
        for (int i = 1; i < 4; i++) begin
            fs_to_ds_bus = pk(i);
            tick();
            check_state($sformatf("fill%0d", i + 1), i + 1, 1'b1);
            check_eq($sformatf("fill%0d head", i + 1), 128'(iq_to_ds_bus), 128'(pk(0)));
        end
        fs_to_ds_bus = pk(4);
        tick();
        check_state("held 5th", 4, 1'b1);
        check_eq("held head", 128'(iq_to_ds_bus), 128'(pk(0)));

        // Full with concurrent pop: pop only, then push+pop.
        ds_allowin = 1'b1;
        tick();
        check_state("full pop", 3, 1'b1);
        check_eq("full pop head", 128'(iq_to_ds_bus), 128'(pk(1)));
        tick();
        check_state("push+pop", 3, 1'b1);
        check_eq("push+pop head", 128'(iq_to_ds_bus), 128'(pk(2)));
        fs_to_ds_valid = 1'b0;
        for (int i = 3; i <= 4; i++) begin
            tick();
            check_eq($sformatf("drain head %0d", i), 128'(iq_to_ds_bus), 128'(pk(i)));
            check_eq($sformatf("drain count %0d", i), 128'(iq_count), 128'(5 - i));
        end
        tick();
        check_state("drained", 0, 1'b0);

        // Streaming: 20 packets, one pop per cycle, count steady at 1.
        fs_to_ds_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fs_to_ds_bus = pk(100 + i);
            tick();
            check_eq($sformatf("stream head %0d", i), 128'(iq_to_ds_bus), 128'(pk(100 + i)));
            check_eq($sformatf("stream count %0d", i), 128'(iq_count), 128'(1));
        end
        fs_to_ds_valid = 1'b0;
        tick();
        check_state("stream end", 0, 1'b0);

        // Flush with three buffered packets; IF's packet in the flush cycle is dropped.
        ds_allowin     = 1'b0;
        fs_to_ds_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fs_to_ds_bus = pk(200 + i);
            tick();
        end
        check_state("pre-flush", 3, 1'b1);
        flush        = 1'b1;
        fs_to_ds_bus = mk(32'h1c00dead, 1'b0, 4'h0);
        #1;
        check_eq("flush cycle valid", 128'(iq_to_ds_valid), 128'(0));
        tick();
        flush          = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        check_state("post-flush", 0, 1'b0);

        // Multi-cycle flush keeps the queue empty.
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = pk(300);
        tick();
        check_state("pre-flush2", 1, 1'b1);
        flush = 1'b1;
        tick();
        check_state("flush2 a", 0, 1'b0);
        tick();
        check_state("flush2 b", 0, 1'b0);
        flush        = 1'b0;
        fs_to_ds_bus = mk(32'h1c008000, 1'b0, 4'h0);
        tick();
        fs_to_ds_valid = 1'b0;
        check_state("after flush", 1, 1'b1);
        check_eq("after flush head", 128'(iq_to_ds_bus), 128'(mk(32'h1c008000, 1'b0, 4'h0)));
        ds_allowin = 1'b1;
        tick();
        check_state("after flush drain", 0, 1'b0);

        // Exception packet forwarded bit-exact.
        ds_allowin     = 1'b0;
        fs_to_ds_valid = 1'b1;
        xp             = mk(32'h1c008004, 1'b1, 4'b0010);
        fs_to_ds_bus   = xp;
        tick();
        check_eq("excp bus", 128'(iq_to_ds_bus), 128'(xp));
        check_eq("excp bit", 128'(iq_to_ds_bus[68]), 128'(1));
        check_eq("excp_num", 128'(iq_to_ds_bus[67:64]), 128'(4'b0010));
        fs_to_ds_bus = pk(400);
        tick();
        fs_to_ds_valid = 1'b0;
        check_state("pre-async", 2, 1'b1);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        #2;
        resetn = 1'b0;
        #1;
        check_state("async reset", 0, 1'b0);
        check_eq("async reset bus", 128'(iq_to_ds_bus), 128'(0));
        #7;
        resetn = 1'b1;
        tick();
        check_state("after async", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
